// File: rtl/avalon_arb_pkg.sv
// Shared types and default widths for the two-master Avalon-MM round-robin arbiter.
//   state_t : arbiter FSM states
//   op_t    : captured downstream operation
package avalon_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 3;
    localparam int unsigned ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/avalon_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req       : request vector, bit N = master N
//   last      : most recently granted master
//   gnt_valid : at least one request present
//   gnt_idx   : winning master index
module avalon_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // On a tie the master that was not granted last wins; otherwise the lone requester.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM bridge port.
// One downstream transaction at a time; read data returns RD_LAT cycles after the strobe.
//   clk, rst_n            : clock, synchronous active-low reset
//   mN_read/write/address/writedata : master requests, held until waitrequest is low
//   mN_waitrequest        : low only in the accept (ISSUE) cycle
//   mN_readdata/readdatavalid       : registered read return to the granted master
//   out_read/write/address/writedata: downstream strobes and payload (registered)
//   out_readdata          : downstream read data, valid RD_LAT cycles after out_read
module avalon_rr_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              out_read,
    output logic              out_write,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_writedata,
    input  logic [DATA_W-1:0] out_readdata
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                out_read_q, out_read_d;
    logic                out_write_q, out_write_d;
    logic [1:0]          wait_q, wait_d;
    logic [1:0]          rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic [1:0]          req;
    logic                gnt_valid;
    logic                gnt_idx;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    avalon_rr_pick2 u_pick (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_read_q  <= 1'b0;
            out_write_q <= 1'b0;
            wait_q      <= 2'b11;
            rdv_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            out_read_q  <= out_read_d;
            out_write_q <= out_write_d;
            wait_q      <= wait_d;
            rdv_q       <= rdv_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Next-state logic; strobes and waitrequest are computed one cycle ahead so they register.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        out_read_d  = 1'b0;
        out_write_d = 1'b0;
        wait_d      = 2'b11;
        rdv_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d         = gnt_idx;
                    last_d          = gnt_idx;
                    // Write wins when a master asserts both strobes.
                    op_d            = (gnt_idx ? m1_write : m0_write) ? OP_WR : OP_RD;
                    addr_d          = gnt_idx ? m1_address : m0_address;
                    wdata_d         = gnt_idx ? m1_writedata : m0_writedata;
                    out_read_d      = (op_d == OP_RD);
                    out_write_d     = (op_d == OP_WR);
                    wait_d[gnt_idx] = 1'b0;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (op_q == OP_RD) begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                // Count of 1 marks the cycle the downstream data is valid.
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d = '0;
                    if (grant_q) rdata1_d = out_readdata;
                    else         rdata0_d = out_readdata;
                    rdv_d[grant_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_waitrequest   = wait_q[0];
    assign m1_waitrequest   = wait_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];
    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;
    assign out_read         = out_read_q;
    assign out_write        = out_write_q;
    assign out_address      = addr_q;
    assign out_writedata    = wdata_q;

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Self-checking bench for avalon_rr_arbiter: directed scenarios plus a randomized
// two-master run checked against a transaction-level reference model.
module tb_avalon_rr_arbiter;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned NCYC   = 3000;
    localparam int unsigned WBOUND = 2 * RD_LAT + 6;

    typedef struct {
        int unsigned due;
        logic        mst;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [2:0]  m0_address, m1_address;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        out_read, out_write;
    logic [2:0]  out_address;
    logic [31:0] out_writedata;
    logic [31:0] out_readdata;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    // Downstream slave model state.
    logic [31:0] mem   [8];
    logic [15:0] ret_v;
    logic [31:0] ret_d [16];

    avalon_rr_arbiter #(
        .ADDR_W (3),
        .DATA_W (32),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .out_read         (out_read),
        .out_write        (out_write),
        .out_address      (out_address),
        .out_writedata    (out_writedata),
        .out_readdata     (out_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory-backed slave: returns mem[addr] exactly RD_LAT cycles after out_read, junk otherwise.
    task automatic downstream();
        forever begin
            @(negedge clk);
            if (out_read === 1'b1) begin
                ret_v[4'(cyc + RD_LAT)] = 1'b1;
                ret_d[4'(cyc + RD_LAT)] = mem[out_address];
            end
            if (out_write === 1'b1) mem[out_address] = out_writedata;
            next_cycle();
            if (ret_v[4'(cyc)]) begin
                out_readdata       = ret_d[4'(cyc)];
                ret_v[4'(cyc)]     = 1'b0;
            end else begin
                out_readdata = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_read, out_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
            bad++;
            $display("FAIL rst_ctrl: got %b want 001100",
                     {out_read, out_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
        end
        total++;
        if ({out_address, out_writedata, m0_readdata, m1_readdata} !== 99'd0) begin
            bad++;
            $display("FAIL rst_data: got addr=%h wd=%h rd0=%h rd1=%h want all 0",
                     out_address, out_writedata, m0_readdata, m1_readdata);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({m1_waitrequest, m0_waitrequest, out_read, out_write} !== 4'b1100) begin
            bad++;
            $display("FAIL idle_wait: got %b want 1100", {m1_waitrequest, m0_waitrequest, out_read, out_write});
        end
    endtask

    task automatic test_single_write();
        next_cycle();
        m0_write = 1'b1; m0_address = 3'd5; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({m0_waitrequest, out_write} !== 2'b10) begin
            bad++;
            $display("FAIL wr_req_cycle: got %b want 10", {m0_waitrequest, out_write});
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({out_write, out_read, m0_waitrequest, m1_waitrequest} !== 4'b1001) begin
            bad++;
            $display("FAIL wr_issue: got %b want 1001", {out_write, out_read, m0_waitrequest, m1_waitrequest});
        end
        total++;
        if (out_address !== 3'd5 || out_writedata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_payload: got %h/%h want 5/deadbeef", out_address, out_writedata);
        end
        next_cycle();
        m0_write = 1'b0;
        @(negedge clk);
        total++;
        if ({out_write, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
            bad++;
            $display("FAIL wr_done: got %b want 011", {out_write, m0_waitrequest, m1_waitrequest});
        end
    endtask

    task automatic test_single_read();
        mem[2] = 32'h12345678;
        next_cycle();
        m1_read = 1'b1; m1_address = 3'd2;
        next_cycle();
        @(negedge clk);
        total++;
        if ({out_read, out_write, m1_waitrequest, m0_waitrequest} !== 4'b1001 || out_address !== 3'd2) begin
            bad++;
            $display("FAIL rd_issue: got %b addr %h want 1001 addr 2",
                     {out_read, out_write, m1_waitrequest, m0_waitrequest}, out_address);
        end
        for (int k = 2; k <= int'(RD_LAT) + 3; k++) begin
            next_cycle();
            if (k == 2) m1_read = 1'b0;
            @(negedge clk);
            total++;
            if ({m1_readdatavalid, m0_readdatavalid} !== {k == int'(RD_LAT) + 2, 1'b0}) begin
                bad++;
                $display("FAIL rd_valid_t%0d: got %b", k, {m1_readdatavalid, m0_readdatavalid});
            end
            if (k == int'(RD_LAT) + 2) begin
                total++;
                if (m1_readdata !== 32'h12345678 || m0_readdata !== 32'h0) begin
                    bad++;
                    $display("FAIL rd_data: got m1=%h m0=%h want 12345678/0", m1_readdata, m0_readdata);
                end
            end
        end
    endtask

    task automatic test_tie_alternation();
        logic [1:0] exp_w;
        do_reset();
        next_cycle();
        m0_write = 1'b1; m0_address = 3'd0; m0_writedata = 32'hA0A0A0A0;
        m1_write = 1'b1; m1_address = 3'd7; m1_writedata = 32'hB1B1B1B1;
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            @(negedge clk);
            exp_w = (k % 2 == 0) ? 2'b11 : ((k % 4 == 1) ? 2'b10 : 2'b01);
            total++;
            if ({m1_waitrequest, m0_waitrequest} !== exp_w) begin
                bad++;
                $display("FAIL tie_k%0d: got %b want %b", k, {m1_waitrequest, m0_waitrequest}, exp_w);
            end
            if (k % 2 == 1) begin
                total++;
                if (out_write !== 1'b1 || out_writedata !== ((k % 4 == 1) ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin
                    bad++;
                    $display("FAIL tie_data_k%0d: got %b/%h", k, out_write, out_writedata);
                end
            end
        end
        next_cycle();
        m0_write = 1'b0; m1_write = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_illegal_rw();
        int  nw, nr, nv, nacc;
        logic seen;
        nw = 0; nr = 0; nv = 0; nacc = 0; seen = 1'b0;
        next_cycle();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 3'd1; m0_writedata = 32'h0BADF00D;
        for (int k = 0; k < int'(RD_LAT) + 8; k++) begin
            @(negedge clk);
            if (out_write === 1'b1) nw++;
            if (out_read !== 1'b0) nr++;
            if (m0_readdatavalid !== 1'b0) nv++;
            if (m0_waitrequest === 1'b0) begin nacc++; seen = 1'b1; end
            next_cycle();
            if (seen) begin m0_read = 1'b0; m0_write = 1'b0; end
        end
        total++;
        if (nw != 1 || nr != 0 || nacc != 1) begin
            bad++;
            $display("FAIL rw_strobes: got wr=%0d rd=%0d acc=%0d want 1/0/1", nw, nr, nacc);
        end
        total++;
        if (nv != 0) begin
            bad++;
            $display("FAIL rw_rdv: got %0d pulses want 0", nv);
        end
        total++;
        if (mem[1] !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL rw_mem: got %h want 0badf00d", mem[1]);
        end
    endtask

    task automatic test_reset_mid_read();
        mem[4] = 32'hCAFE0004;
        next_cycle();
        m0_read = 1'b1; m0_address = 3'd4;
        next_cycle();
        @(negedge clk);
        total++;
        if ({out_read, m0_waitrequest} !== 2'b10) begin
            bad++;
            $display("FAIL mid_issue: got %b want 10", {out_read, m0_waitrequest});
        end
        next_cycle();
        m0_read = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if ({out_read, out_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100
            || {out_address, out_writedata, m0_readdata, m1_readdata} !== 99'd0) begin
            bad++;
            $display("FAIL mid_rst: ctl=%b addr=%h wd=%h rd0=%h rd1=%h",
                     {out_read, out_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid},
                     out_address, out_writedata, m0_readdata, m1_readdata);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < int'(RD_LAT) + 4; k++) begin
            @(negedge clk);
            total++;
            if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
                bad++;
                $display("FAIL mid_no_rdv_k%0d: got %b", k, {m0_readdatavalid, m1_readdatavalid});
            end
            next_cycle();
        end
        m0_write = 1'b1; m0_address = 3'd3; m0_writedata = 32'h11110000;
        m1_write = 1'b1; m1_address = 3'd6; m1_writedata = 32'h22220000;
        next_cycle();
        @(negedge clk);
        total++;
        if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin
            bad++;
            $display("FAIL mid_first_tie: got %b want 10", {m1_waitrequest, m0_waitrequest});
        end
        next_cycle();
        m0_write = 1'b0; m1_write = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_back_to_back();
        int unsigned a1, v1, a2, v2;
        a1 = 1; v1 = RD_LAT + 2; a2 = RD_LAT + 3; v2 = 2 * RD_LAT + 4;
        mem[6] = 32'h66666666; mem[7] = 32'h77777777;
        for (int unsigned k = 0; k <= 2 * RD_LAT + 6; k++) begin
            next_cycle();
            if (k == 0) begin m0_read = 1'b1; m0_address = 3'd6; end
            if (k == 2) m0_address = 3'd7;
            if (k == a2 + 1) m0_read = 1'b0;
            @(negedge clk);
            total++;
            if (m0_waitrequest !== !(k == a1 || k == a2)) begin
                bad++;
                $display("FAIL b2b_wait_k%0d: got %b", k, m0_waitrequest);
            end
            total++;
            if (m0_readdatavalid !== (k == v1 || k == v2)) begin
                bad++;
                $display("FAIL b2b_rdv_k%0d: got %b", k, m0_readdatavalid);
            end
            if (k == v1 || k == v2) begin
                total++;
                if (m0_readdata !== ((k == v1) ? 32'h66666666 : 32'h77777777)) begin
                    bad++;
                    $display("FAIL b2b_data_k%0d: got %h", k, m0_readdata);
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        logic        act [2];
        logic        rd  [2];
        logic [2:0]  ad  [2];
        logic [31:0] wd  [2];
        int unsigned waited [2];
        logic [31:0] ref_mem [8];
        logic [1:0]  prev_req, cur_req, acc, exp_v;
        logic        last_ref, exp_m;
        logic [31:0] rdata, v;
        int          m;

        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        do_reset();
        last_ref = 1'b1;
        prev_req = 2'b00;
        for (int i = 0; i < 2; i++) begin act[i] = 1'b0; rd[i] = 1'b0; ad[i] = '0; wd[i] = '0; waited[i] = 0; end

        for (int unsigned t = 0; t < NCYC; t++) begin
            next_cycle();
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && t < NCYC - 60 && $urandom_range(0, 2) == 0) begin
                    act[i]    = 1'b1;
                    rd[i]     = 1'($urandom_range(0, 1));
                    ad[i]     = 3'($urandom_range(0, 7));
                    wd[i]     = $urandom;
                    waited[i] = 0;
                end
            end
            m0_read = act[0] & rd[0]; m0_write = act[0] & ~rd[0];
            m0_address = ad[0]; m0_writedata = wd[0];
            m1_read = act[1] & rd[1]; m1_write = act[1] & ~rd[1];
            m1_address = ad[1]; m1_writedata = wd[1];
            @(negedge clk);

            cur_req = {act[1], act[0]};
            acc     = {~m1_waitrequest, ~m0_waitrequest};
            total++;
            if (acc === 2'b11 || (acc & ~cur_req) !== 2'b00) begin
                bad++;
                $display("FAIL rnd_accept_t%0d: acc=%b req=%b", t, acc, cur_req);
            end
            if (acc === 2'b01 || acc === 2'b10) begin
                m     = int'(acc[1]);
                exp_m = (prev_req == 2'b11) ? ~last_ref : prev_req[1];
                total++;
                if (prev_req == 2'b00 || acc[1] !== exp_m) begin
                    bad++;
                    $display("FAIL rnd_arb_t%0d: got m%0d want m%0d prev_req=%b", t, m, exp_m, prev_req);
                end
                total++;
                if ({out_read, out_write} !== {rd[m], ~rd[m]} || out_address !== ad[m]
                    || (!rd[m] && out_writedata !== wd[m])) begin
                    bad++;
                    $display("FAIL rnd_issue_t%0d: got %b a=%h d=%h want rd=%b a=%h d=%h",
                             t, {out_read, out_write}, out_address, out_writedata, rd[m], ad[m], wd[m]);
                end
                total++;
                if (waited[m] > WBOUND) begin
                    bad++;
                    $display("FAIL rnd_starve_t%0d: m%0d waited %0d", t, m, waited[m]);
                end
                if (rd[m]) q.push_back('{due: t + 1 + RD_LAT, mst: acc[1], data: ref_mem[ad[m]]});
                else       ref_mem[ad[m]] = wd[m];
                last_ref = acc[1];
                act[m]   = 1'b0;
            end else begin
                total++;
                if ({out_read, out_write} !== 2'b00) begin
                    bad++;
                    $display("FAIL rnd_idle_strobe_t%0d: got %b", t, {out_read, out_write});
                end
            end

            exp_v = 2'b00;
            if (q.size() > 0 && q[0].due == t) exp_v[q[0].mst] = 1'b1;
            total++;
            if ({m1_readdatavalid, m0_readdatavalid} !== exp_v) begin
                bad++;
                $display("FAIL rnd_rdv_t%0d: got %b want %b", t, {m1_readdatavalid, m0_readdatavalid}, exp_v);
            end else if (exp_v != 2'b00) begin
                rdata = q[0].mst ? m1_readdata : m0_readdata;
                total++;
                if (rdata !== q[0].data) begin
                    bad++;
                    $display("FAIL rnd_rdata_t%0d: got %h want %h", t, rdata, q[0].data);
                end
            end
            if (exp_v != 2'b00) void'(q.pop_front());

            for (int i = 0; i < 2; i++) if (act[i]) waited[i]++;
            prev_req = cur_req;
        end
        total++;
        if (act[0] || act[1] || q.size() != 0) begin
            bad++;
            $display("FAIL rnd_drain: pending req=%b%b reads=%0d", act[1], act[0], q.size());
        end
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0;
        out_readdata = '0;
        ret_v = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) ret_d[i] = '0;
        fork
            downstream();
        join_none

        test_reset();
        test_single_write();
        test_single_read();
        test_tie_alternation();
        test_illegal_rw();
        test_reset_mid_read();
        test_back_to_back();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
